// File: rtl/fmap_restreamer.sv
// Captures one feature map of wide accumulators, requantizes to int8 and
// replays it as a gap-free raster pixel stream for the next conv layer.
module fmap_restreamer #(
  parameter int FM_W   = 3,
  parameter int FM_H   = 3,
  parameter int DATA_W = 8,
  parameter int ACC_W  = 25,
  parameter int SHIFT  = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic signed [ACC_W-1:0]  in_data,
  output logic                     valid_pixel,
  output logic signed [DATA_W-1:0] pixel_out,
  output logic                     busy,
  output logic                     frame_done,
  output logic                     overflow
);

  localparam int N     = FM_W * FM_H;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);
  localparam logic signed [ACC_W-1:0] Q_MAX = ACC_W'((1 << (DATA_W - 1)) - 1);

  typedef enum logic {FILL, SEND} state_t;

  state_t                    state, next_state;
  logic [IDX_W-1:0]          wr_idx, wr_idx_n, rd_idx, rd_idx_n;
  logic                      wr_en, valid_n, done_n, overflow_n;
  logic signed [DATA_W-1:0]  pixel_n, q_data;
  logic signed [ACC_W-1:0]   shifted;
  logic [DATA_W-1:0]         fbuf [N];

  // ReLU, shift and saturate; full accumulator width is kept until the clamp
  always_comb begin
    shifted = in_data >>> SHIFT;
    if (in_data[ACC_W-1])
      q_data = '0;
    else if (shifted > Q_MAX)
      q_data = DATA_W'(Q_MAX);
    else
      q_data = shifted[DATA_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= FILL;
      wr_idx      <= '0;
      rd_idx      <= '0;
      valid_pixel <= 1'b0;
      pixel_out   <= '0;
      frame_done  <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      state       <= next_state;
      wr_idx      <= wr_idx_n;
      rd_idx      <= rd_idx_n;
      valid_pixel <= valid_n;
      pixel_out   <= pixel_n;
      frame_done  <= done_n;
      overflow    <= overflow_n;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en && !rst)
      fbuf[wr_idx] <= q_data;
  end

  always_comb begin
    next_state = state;
    case (state)
      FILL:    if (in_valid && wr_idx == LAST_IDX) next_state = SEND;
      SEND:    if (rd_idx == LAST_IDX) next_state = FILL;
      default: next_state = FILL;
    endcase
  end

  // In FILL, a still-high valid_pixel marks the cycle of the last pixel
  always_comb begin
    wr_en      = 1'b0;
    wr_idx_n   = wr_idx;
    rd_idx_n   = rd_idx;
    valid_n    = 1'b0;
    pixel_n    = pixel_out;
    done_n     = 1'b0;
    overflow_n = overflow;
    case (state)
      FILL: begin
        done_n = valid_pixel;
        if (in_valid) begin
          wr_en = 1'b1;
          if (wr_idx == LAST_IDX) begin
            wr_idx_n = '0;
            rd_idx_n = '0;
          end else begin
            wr_idx_n = wr_idx + 1'b1;
          end
        end
      end
      SEND: begin
        valid_n  = 1'b1;
        pixel_n  = fbuf[rd_idx];
        rd_idx_n = (rd_idx == LAST_IDX) ? '0 : rd_idx + 1'b1;
        if (in_valid) overflow_n = 1'b1;
      end
      default: ;
    endcase
  end

  assign busy = (state == SEND) || valid_pixel;

endmodule

// File: tb/tb_fmap_restreamer.sv
// Self-checking bench: two instances (SHIFT 0 and 1) on shared stimulus, checked by a
// frame-level timeline model every cycle plus table vectors and corner-case sequences.
module tb_fmap_restreamer;

  localparam int FM_W   = 3;
  localparam int FM_H   = 3;
  localparam int N      = FM_W * FM_H;
  localparam int DATA_W = 8;
  localparam int ACC_W  = 25;

  logic clk = 1'b0;
  logic rst;
  logic in_valid;
  logic signed [ACC_W-1:0] in_data;
  logic vp0, vp1, busy0, busy1, fd0, fd1, ov0, ov1;
  logic signed [DATA_W-1:0] px0, px1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fmap_restreamer #(.FM_W(FM_W), .FM_H(FM_H), .DATA_W(DATA_W), .ACC_W(ACC_W), .SHIFT(0)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .valid_pixel(vp0), .pixel_out(px0), .busy(busy0), .frame_done(fd0), .overflow(ov0)
  );

  fmap_restreamer #(.FM_W(FM_W), .FM_H(FM_H), .DATA_W(DATA_W), .ACC_W(ACC_W), .SHIFT(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .valid_pixel(vp1), .pixel_out(px1), .busy(busy1), .frame_done(fd1), .overflow(ov1)
  );

  typedef struct {
    int in_val;
    int exp0;
    int exp1;
  } vec_t;

  vec_t vec_a[N];
  vec_t vec_b[N];

  // Reference model state: accepted samples of the frame being filled, and the
  // edge index at which the last sample of the most recent frame was accepted
  longint fill_q[$];
  int     burst0[N];
  int     burst1[N];
  int     cyc = 0;
  int     t_edge;
  int     e_edge = 0;
  bit     have_burst = 0;
  int     last0 = 0;
  int     last1 = 0;
  bit     exp_ov = 0;
  bit     check_en = 0;
  int     sum0 = 0;
  int     k;
  bit     ev, eb, ed;

  function automatic int ref_q(input longint x, input int shift);
    longint y;
    if (x < 0) return 0;
    y = x / (longint'(1) << shift);
    return (y > 127) ? 127 : int'(y);
  endfunction

  function automatic longint rand_acc();
    logic signed [ACC_W-1:0] r;
    case ($urandom_range(0, 3))
      0: return longint'($urandom_range(0, 300));
      1: return -longint'($urandom_range(1, 100000));
      2: begin
        r = ACC_W'($urandom);
        return longint'(r);
      end
      default: return longint'($urandom_range(0, 255));
    endcase
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input bit v, input longint d);
    in_valid = v;
    in_data  = ACC_W'(d);
    @(negedge clk);
  endtask

  initial forever begin
    @(posedge clk);
    t_edge = cyc + 1;
    if (rst) begin
      fill_q.delete();
      have_burst = 0;
      last0 = 0;
      last1 = 0;
      exp_ov = 0;
    end else begin
      if (have_burst && t_edge >= e_edge + 1 && t_edge <= e_edge + N) begin
        last0 = burst0[t_edge - e_edge - 1];
        last1 = burst1[t_edge - e_edge - 1];
      end
      if (in_valid) begin
        if (have_burst && t_edge >= e_edge + 1 && t_edge <= e_edge + N) begin
          exp_ov = 1;
        end else begin
          fill_q.push_back(longint'(in_data));
          if (fill_q.size() == N) begin
            for (int i = 0; i < N; i++) begin
              burst0[i] = ref_q(fill_q[i], 0);
              burst1[i] = ref_q(fill_q[i], 1);
            end
            e_edge = t_edge;
            have_burst = 1;
            fill_q.delete();
          end
        end
      end
    end
    cyc = t_edge;
  end

  initial forever begin
    @(negedge clk);
    if (check_en) begin
      k  = cyc - e_edge;
      ev = have_burst && k >= 1 && k <= N;
      eb = have_burst && k >= 0 && k <= N;
      ed = have_burst && k == N + 1;
      checkOutput("mon_valid0", int'(vp0), int'(ev));
      checkOutput("mon_valid1", int'(vp1), int'(ev));
      checkOutput("mon_busy0", int'(busy0), int'(eb));
      checkOutput("mon_busy1", int'(busy1), int'(eb));
      checkOutput("mon_done0", int'(fd0), int'(ed));
      checkOutput("mon_done1", int'(fd1), int'(ed));
      checkOutput("mon_ovf0", int'(ov0), int'(exp_ov));
      checkOutput("mon_ovf1", int'(ov1), int'(exp_ov));
      checkOutput("mon_pixel0", int'(px0), last0);
      checkOutput("mon_pixel1", int'(px1), last1);
    end
    if (vp0 === 1'b1) sum0 += int'(px0);
  end

  task automatic runVectors(input int which, input bit gappy, input bit inject, input int exp_ovf);
    vec_t e;
    for (int i = 0; i < N; i++) begin
      e = (which == 0) ? vec_a[i] : vec_b[i];
      applyStimulus(1'b1, longint'(e.in_val));
      if (gappy && i < N - 1) repeat ((i % 2 == 0) ? 2 : 1) applyStimulus(1'b0, 0);
    end
    in_valid = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (inject && i == 2) begin
        in_valid = 1'b1;
        in_data  = ACC_W'(50);
      end else if (inject && i == 5) begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      e = (which == 0) ? vec_a[i] : vec_b[i];
      checkOutput($sformatf("vec%0d_valid_%0d", which, i), int'(vp0), 1);
      checkOutput($sformatf("vec%0d_pix0_%0d", which, i), int'(px0), e.exp0);
      checkOutput($sformatf("vec%0d_pix1_%0d", which, i), int'(px1), e.exp1);
    end
    in_valid = 1'b0;
    @(negedge clk);
    checkOutput($sformatf("vec%0d_frame_done", which), int'(fd0), 1);
    checkOutput($sformatf("vec%0d_valid_after", which), int'(vp0), 0);
    checkOutput($sformatf("vec%0d_overflow", which), int'(ov0), exp_ovf);
  endtask

  int s;

  initial begin
    vec_a[0] = '{1, 1, 0};       vec_a[1] = '{2, 2, 1};     vec_a[2] = '{3, 3, 1};
    vec_a[3] = '{4, 4, 2};       vec_a[4] = '{5, 5, 2};     vec_a[5] = '{6, 6, 3};
    vec_a[6] = '{7, 7, 3};       vec_a[7] = '{8, 8, 4};     vec_a[8] = '{9, 9, 4};
    vec_b[0] = '{-5, 0, 0};      vec_b[1] = '{0, 0, 0};     vec_b[2] = '{200, 127, 100};
    vec_b[3] = '{255, 127, 127}; vec_b[4] = '{256, 127, 127}; vec_b[5] = '{300, 127, 127};
    vec_b[6] = '{1000000, 127, 127}; vec_b[7] = '{-1, 0, 0}; vec_b[8] = '{3, 3, 1};

    rst = 1'b1;
    in_valid = 1'b0;
    in_data = '0;
    repeat (2) @(negedge clk);
    checkOutput("reset_valid", int'(vp0), 0);
    checkOutput("reset_pixel", int'(px0), 0);
    checkOutput("reset_busy", int'(busy0), 0);
    checkOutput("reset_done", int'(fd0), 0);
    checkOutput("reset_overflow", int'(ov0), 0);
    check_en = 1;
    rst = 1'b0;
    @(negedge clk);

    runVectors(0, 1'b0, 1'b0, 0);
    runVectors(1, 1'b0, 1'b0, 0);
    runVectors(0, 1'b1, 1'b0, 0);
    runVectors(0, 1'b0, 1'b1, 1);
    runVectors(0, 1'b0, 1'b0, 1);

    // Reset in the cycle showing the 4th pixel, with a sample that must be dropped
    for (int i = 1; i <= N; i++) applyStimulus(1'b1, longint'(i));
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b1;
    in_data = ACC_W'(77);
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b0;
    checkOutput("midrst_valid", int'(vp0), 0);
    checkOutput("midrst_busy", int'(busy0), 0);
    checkOutput("midrst_pixel", int'(px0), 0);
    checkOutput("midrst_overflow", int'(ov0), 0);
    runVectors(0, 1'b0, 1'b0, 0);

    // Back-to-back frames; a 3x3 ones kernel over a 3x3 map sums every pixel
    s = sum0;
    for (int i = 1; i <= N; i++) applyStimulus(1'b1, longint'(i));
    in_valid = 1'b0;
    repeat (N + 1) @(negedge clk);
    checkOutput("b2b_done1", int'(fd0), 1);
    checkOutput("b2b_convsum1", sum0 - s, 45);
    s = sum0;
    for (int i = 10; i <= 18; i++) applyStimulus(1'b1, longint'(i));
    in_valid = 1'b0;
    repeat (N + 1) @(negedge clk);
    checkOutput("b2b_done2", int'(fd0), 1);
    checkOutput("b2b_convsum2", sum0 - s, 126);
    checkOutput("b2b_overflow", int'(ov0), 0);

    repeat (8) begin
      for (int i = 0; i < N; i++) begin
        applyStimulus(1'b1, rand_acc());
        repeat ($urandom_range(0, 2)) applyStimulus(1'b0, 0);
      end
      repeat (N + 2) applyStimulus($urandom_range(0, 7) == 0, rand_acc());
    end
    in_valid = 1'b0;
    repeat (2 * N + 4) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
